timer_scheduler: RTL and testbench

Shares the single one-shot 100 ms timer (start pulse in, expired pulse out) among N_REQ requesters such as the steering, throttle and sensor-poll controllers. Each requester asks for a delay of `ticks` timer periods. The scheduler arbitrates round-robin, re-arms the timer once per tick, and pulses a per-requester `done` when the delay completes. It sits between the control FSMs and the timer instance.

---
 rtl/timer_scheduler.sv | 143 ++++++++++++++
 tb/tb_timer_scheduler.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_scheduler.sv
// Round-robin scheduler sharing one one-shot timer among N_REQ requesters, re-arming it once per tick.
// Optional watchdog on a missing expiry is built when TIMER_SCHED_WDOG_EN is defined.
module timer_scheduler #(
    parameter int N_REQ       = 4,
    parameter int TICK_W      = 8,
    parameter int WDOG_CYCLES = 12600000,
    parameter int WDOG_W      = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*TICK_W-1:0] ticks,
    input  logic                    tmr_expired,
    output logic                    tmr_start,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic [N_REQ-1:0]        done,
    output logic                    err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [TICK_W-1:0]  remaining;

    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   scan_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [TICK_W-1:0]  pick_ticks;

    // A watchdog limit that does not fit its counter can never fire.
    if (WDOG_CYCLES < 1 || longint'(WDOG_CYCLES) >= (64'(1) << WDOG_W)) begin : g_bad_wdog
        $error("WDOG_CYCLES does not fit in WDOG_W bits");
    end

`ifdef TIMER_SCHED_WDOG_EN
    logic [WDOG_W-1:0]  wdog;
`else
    assign err = 1'b0;
`endif

    // Round-robin pick: first set request at or above the pointer, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = {PTR_W{1'b0}};
        scan_idx   = {PTR_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!pick_valid && req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end else begin
                pick_valid = pick_valid;
            end
        end
        pick_ticks = ticks[pick_idx*TICK_W +: TICK_W];
        next_ptr   = (pick_idx == PTR_W'(N_REQ - 1)) ? {PTR_W{1'b0}} : pick_idx + PTR_W'(1);
    end

    // Scheduler FSM with registered pulse and level outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= {PTR_W{1'b0}};
            remaining <= {TICK_W{1'b0}};
            grant     <= {N_REQ{1'b0}};
            done      <= {N_REQ{1'b0}};
            tmr_start <= 1'b0;
            busy      <= 1'b0;
`ifdef TIMER_SCHED_WDOG_EN
            wdog      <= {WDOG_W{1'b0}};
            err       <= 1'b0;
`endif
        end else begin
            tmr_start <= 1'b0;
            done      <= {N_REQ{1'b0}};
`ifdef TIMER_SCHED_WDOG_EN
            err       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant     <= N_REQ'(1'b1) << pick_idx;
                        remaining <= pick_ticks;
                        ptr       <= next_ptr;
                        busy      <= 1'b1;
                        // A zero-tick request completes without arming the timer.
                        if (pick_ticks != {TICK_W{1'b0}}) begin
                            state     <= START;
                            tmr_start <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= N_REQ'(1'b1) << pick_idx;
                        end
                    end
                end
                START: begin
                    state <= WAIT;
`ifdef TIMER_SCHED_WDOG_EN
                    wdog  <= {WDOG_W{1'b0}};
`endif
                end
                WAIT: begin
                    if (tmr_expired && remaining != {TICK_W{1'b0}}) begin
                        remaining <= remaining - TICK_W'(1);
                        if (remaining == TICK_W'(1)) begin
                            state <= DONE;
                            done  <= grant;
                        end else begin
                            state     <= START;
                            tmr_start <= 1'b1;
                        end
                    end
`ifdef TIMER_SCHED_WDOG_EN
                    else if (wdog == WDOG_W'(WDOG_CYCLES - 1)) begin
                        state     <= DONE;
                        done      <= grant;
                        err       <= 1'b1;
                        remaining <= {TICK_W{1'b0}};
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
`endif
                end
                DONE: begin
                    grant <= {N_REQ{1'b0}};
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    grant <= {N_REQ{1'b0}};
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_scheduler.sv
// Self-checking bench for timer_scheduler: directed scenarios plus randomized traffic against
// a cycle-formula reference model; a behavioural one-shot timer (C=10) drives tmr_expired.
module tb_timer_scheduler;

    localparam int N  = 4;
    localparam int TW = 8;
    localparam int C  = 10;
    localparam int WD = 50;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*TW-1:0] ticks = '0;
    logic            tmr_expired = 1'b0;
    logic            tmr_start;
    logic [N-1:0]    grant;
    logic            busy;
    logic [N-1:0]    done;
    logic            err;

    int checks = 0;
    int errors = 0;
    bit timer_on = 1'b1;
    bit force_exp = 1'b0;
    int tcount = 0;

    timer_scheduler #(.N_REQ(N), .TICK_W(TW), .WDOG_CYCLES(WD), .WDOG_W(24)) dut (
        .clk(clk), .reset(reset), .req(req), .ticks(ticks), .tmr_expired(tmr_expired),
        .tmr_start(tmr_start), .grant(grant), .busy(busy), .done(done), .err(err)
    );

    always #4 clk = ~clk;

    // Behavioural one-shot timer: expiry C+1 cycles after the start cycle; ignores start while running.
    initial begin
        bit texp;
        forever begin
            @(negedge clk);
            if (reset) begin
                tcount = 0;
                tmr_expired = 1'b0;
            end else begin
                texp = 1'b0;
                if (tcount > 0) begin
                    tcount--;
                    texp = (tcount == 0);
                end
                if (timer_on && tmr_start === 1'b1 && tcount == 0) tcount = C + 1;
                tmr_expired = texp | force_exp;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    function automatic logic [N-1:0] oh(int i);
        return N'(1) << i;
    endfunction

    task automatic set_ticks(int i, int v);
        ticks[i*TW +: TW] = TW'(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        force_exp = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant, busy, done, tmr_start, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %0h exp 0", {grant, busy, done, tmr_start, err});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({grant, busy, done, tmr_start, err} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle got %0h exp 0", {grant, busy, done, tmr_start, err});
        end
    endtask

    task automatic test_round_robin();
        for (int r = 0; r < 2; r++) begin
            int g0 = -1;
            int g2 = -1;
            next_cycle();
            set_ticks(0, 1);
            set_ticks(2, 1);
            req = 4'b0101;
            for (int n = 0; n <= 40; n++) begin
                logic [N-1:0] seen;
                @(negedge clk);
                if (grant === 4'b0001 && g0 < 0) g0 = n;
                if (grant === 4'b0100 && g2 < 0) g2 = n;
                seen = done;
                next_cycle();
                req = req & ~seen;
            end
            checks++;
            if (g0 != 1) begin
                errors++;
                $display("FAIL rr_grant0_round%0d got %0d exp 1", r, g0);
            end
            checks++;
            if (g2 != 1 + (C + 2) + 2) begin
                errors++;
                $display("FAIL rr_grant2_round%0d got %0d exp %0d", r, g2, 1 + (C + 2) + 2);
            end
        end
    endtask

    task automatic test_basic();
        int starts[$];
        int done_at = -1;
        int bad_grant = 0;
        next_cycle();
        set_ticks(0, 3);
        req[0] = 1'b1;
        for (int n = 0; n <= 60; n++) begin
            logic [N-1:0] eg;
            @(negedge clk);
            if (tmr_start === 1'b1) starts.push_back(n);
            if (done !== '0 && done_at < 0) begin
                done_at = n;
                checks++;
                if (done !== 4'b0001) begin
                    errors++;
                    $display("FAIL basic_done_vec got %b exp 0001", done);
                end
            end
            eg = (n >= 1 && n <= 1 + 3 * (C + 2)) ? 4'b0001 : 4'b0000;
            if (grant !== eg) bad_grant++;
            next_cycle();
            if (done_at == n) req[0] = 1'b0;
        end
        checks++;
        if (starts.size() != 3) begin
            errors++;
            $display("FAIL basic_start_count got %0d exp 3", starts.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (starts[k] != 1 + k * (C + 2)) begin
                    errors++;
                    $display("FAIL basic_start%0d got %0d exp %0d", k, starts[k], 1 + k * (C + 2));
                end
            end
        end
        checks++;
        if (done_at != 1 + 3 * (C + 2)) begin
            errors++;
            $display("FAIL basic_done_cycle got %0d exp %0d", done_at, 1 + 3 * (C + 2));
        end
        checks++;
        if (bad_grant != 0) begin
            errors++;
            $display("FAIL basic_grant_window got %0d bad cycles exp 0", bad_grant);
        end
    endtask

    task automatic test_zero_ticks();
        int nstart = 0;
        next_cycle();
        set_ticks(1, 0);
        req[1] = 1'b1;
        for (int n = 0; n <= 6; n++) begin
            @(negedge clk);
            if (tmr_start === 1'b1) nstart++;
            if (n == 1) begin
                checks++;
                if (grant !== 4'b0010 || done !== 4'b0010) begin
                    errors++;
                    $display("FAIL zero_grant_done got %b/%b exp 0010/0010", grant, done);
                end
            end
            if (n == 3) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL zero_busy_after got %b exp 0", busy);
                end
            end
            next_cycle();
            if (n == 1) req[1] = 1'b0;
        end
        checks++;
        if (nstart != 0) begin
            errors++;
            $display("FAIL zero_no_start got %0d exp 0", nstart);
        end
    endtask

    task automatic test_reset_mid();
        int spurious = 0;
        int g = -1;
        int d = -1;
        next_cycle();
        set_ticks(2, 5);
        req[2] = 1'b1;
        repeat (20) next_cycle();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant !== 4'b0100) begin
            errors++;
            $display("FAIL midreset_pre got busy %b grant %b exp 1/0100", busy, grant);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({grant, busy, done, tmr_start, err} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got %0h exp 0", {grant, busy, done, tmr_start, err});
        end
        req = '0;
        @(negedge clk);
        next_cycle();
        reset = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (done !== '0 || busy !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL midreset_no_done got %0d active cycles exp 0", spurious);
        end
        next_cycle();
        set_ticks(3, 1);
        req[3] = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            @(negedge clk);
            if (grant === 4'b1000 && g < 0) g = n;
            if (done === 4'b1000 && d < 0) d = n;
            next_cycle();
            if (d == n) req[3] = 1'b0;
        end
        checks++;
        if (g != 1 || d != 1 + (C + 2)) begin
            errors++;
            $display("FAIL midreset_regrant got %0d/%0d exp 1/%0d", g, d, 1 + (C + 2));
        end
    endtask

    task automatic test_idle_expiry_drop();
        int moved = 0;
        int d = -1;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            force_exp = (k % 2 == 0);
            @(negedge clk);
            if (busy !== 1'b0 || grant !== '0 || done !== '0) moved++;
        end
        next_cycle();
        force_exp = 1'b0;
        checks++;
        if (moved != 0) begin
            errors++;
            $display("FAIL idle_expiry_ignored got %0d moves exp 0", moved);
        end
        set_ticks(1, 2);
        req[1] = 1'b1;
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            if (done !== '0 && d < 0) begin
                d = n;
                checks++;
                if (done !== 4'b0010) begin
                    errors++;
                    $display("FAIL drop_done_vec got %b exp 0010", done);
                end
            end
            next_cycle();
            if (n == 5) req[1] = 1'b0;
            set_ticks(1, 200);
        end
        checks++;
        if (d != 1 + 2 * (C + 2)) begin
            errors++;
            $display("FAIL drop_done_cycle got %0d exp %0d", d, 1 + 2 * (C + 2));
        end
    endtask

    task automatic test_random();
        int m_owner = -1;
        int m_g = 0;
        int m_d = -1;
        int m_k = 0;
        int m_ptr = 0;
        logic [N-1:0] drop = '0;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic [N-1:0] eg;
            logic [N-1:0] ed;
            logic es;
            logic eb;
            bit active;
            force_exp = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (drop[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 7) == 0) begin
                    set_ticks(i, int'($urandom_range(0, 3)));
                    req[i] = 1'b1;
                end
            end
            if (m_owner >= 0 && n >= m_g && n < m_d && $urandom_range(0, 3) == 0)
                set_ticks(m_owner, int'($urandom_range(0, 255)));
            if ((m_owner < 0 || n >= m_d) && $urandom_range(0, 4) == 0) force_exp = 1'b1;
            @(negedge clk);
            active = (m_owner >= 0 && n >= m_g && n <= m_d);
            eg = active ? oh(m_owner) : '0;
            ed = (active && n == m_d) ? oh(m_owner) : '0;
            es = active && n < m_d && ((n - m_g) % (C + 2)) == 0;
            eb = active;
            checks++;
            if (grant !== eg) begin
                errors++;
                $display("FAIL rand_grant cyc %0d got %b exp %b", n, grant, eg);
            end
            checks++;
            if (done !== ed) begin
                errors++;
                $display("FAIL rand_done cyc %0d got %b exp %b", n, done, ed);
            end
            checks++;
            if (tmr_start !== es) begin
                errors++;
                $display("FAIL rand_start cyc %0d got %b exp %b", n, tmr_start, es);
            end
            checks++;
            if (busy !== eb || err !== 1'b0) begin
                errors++;
                $display("FAIL rand_busy_err cyc %0d got %b%b exp %b0", n, busy, err, eb);
            end
            drop = ed;
            if ((m_owner < 0 || n > m_d) && req != '0) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (req[j]) begin
                        m_owner = j;
                        m_k = int'(ticks[j*TW +: TW]);
                        m_g = n + 1;
                        m_d = n + 1 + m_k * (C + 2);
                        m_ptr = (j + 1) % N;
                        break;
                    end
                end
            end
            next_cycle();
        end
        force_exp = 1'b0;
    endtask

`ifdef TIMER_SCHED_WDOG_EN
    task automatic test_watchdog();
        int starts[$];
        int d = -1;
        do_reset();
        timer_on = 1'b0;
        set_ticks(0, 4);
        req[0] = 1'b1;
        for (int n = 0; n <= 80; n++) begin
            @(negedge clk);
            if (tmr_start === 1'b1) starts.push_back(n);
            if (done !== '0 && d < 0) begin
                d = n;
                checks++;
                if (done !== 4'b0001 || err !== 1'b1) begin
                    errors++;
                    $display("FAIL wdog_done_err got %b/%b exp 0001/1", done, err);
                end
            end
            if (n == d + 2) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL wdog_back_idle got %b exp 0", busy);
                end
            end
            next_cycle();
            if (d == n) req[0] = 1'b0;
        end
        checks++;
        if (starts.size() != 1 || d != 1 + WD + 1) begin
            errors++;
            $display("FAIL wdog_timing got starts %0d done %0d exp 1/%0d", starts.size(), d, WD + 2);
        end
        timer_on = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_basic();
        test_zero_ticks();
        test_reset_mid();
        test_idle_expiry_drop();
        test_random();
`ifdef TIMER_SCHED_WDOG_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
